// File: rtl/shift_wb_pkg.sv
// Shared widths, flag bit positions and the FIFO entry layout for shift_writeback.
// SHIFT_WB_HILO_EN adds the res_high/wr_hilo fields to the entry.
package shift_wb_pkg;

  localparam int WB_WIDTH = 32;
  localparam int WB_TAG_W = 5;
  localparam int WB_AMT_W = 5;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;

  typedef struct packed {
`ifdef SHIFT_WB_HILO_EN
    logic [WB_WIDTH-1:0] res_high;
`endif
    logic [WB_WIDTH-1:0] res_low;
    logic [WB_AMT_W-1:0] amount;
    logic [WB_TAG_W-1:0] tag;
`ifdef SHIFT_WB_HILO_EN
    logic                wr_hilo;
`endif
  } entry_t;

  // C is the last bit rotated out of bit 0, which lands in the result MSB.
  function automatic logic [2:0] calc_flags(input logic [WB_WIDTH-1:0] res,
                                            input logic [WB_AMT_W-1:0] amt);
    logic [2:0] f;
    f         = '0;
    f[FLAG_Z] = (res == '0);
    f[FLAG_N] = res[WB_WIDTH-1];
    f[FLAG_C] = (amt != '0) ? res[WB_WIDTH-1] : 1'b0;
    return f;
  endfunction

endpackage

// File: rtl/shift_wb_fifo.sv
// Two-entry synchronous FIFO of rotator results with wrapping read/write pointers.
module shift_wb_fifo
  import shift_wb_pkg::*;
(
  input  logic   clock,
  input  logic   reset_n,
  input  logic   i_push,
  input  entry_t i_data,
  input  logic   i_pop,
  output logic   o_full,
  output logic   o_empty,
  output entry_t o_head
);

  entry_t     r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       w_do_push;
  logic       w_do_pop;

  assign o_full    = (r_count == 2'd2);
  assign o_empty   = (r_count == 2'd0);
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/shift_writeback.sv
// Writeback stage after the rotate-right unit: buffers results, commits Z/N/C flags
// and (with SHIFT_WB_HILO_EN defined) the HI/LO registers when an entry is popped.
module shift_writeback
  import shift_wb_pkg::*;
#(
  parameter int WIDTH = WB_WIDTH,
  parameter int TAG_W = WB_TAG_W,
  parameter int AMT_W = WB_AMT_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_res_high,
  input  logic [WIDTH-1:0] in_res_low,
  input  logic [AMT_W-1:0] in_amount,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_wr_hilo,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [WIDTH-1:0] hi_q,
  output logic [WIDTH-1:0] lo_q,
  output logic [2:0]       flags_q
);

  entry_t     w_in_entry;
  entry_t     w_head;
  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  logic [2:0] r_flags;

  always_comb begin
    w_in_entry          = '0;
    w_in_entry.res_low  = in_res_low;
    w_in_entry.amount   = in_amount;
    w_in_entry.tag      = in_tag;
`ifdef SHIFT_WB_HILO_EN
    w_in_entry.res_high = in_res_high;
    w_in_entry.wr_hilo  = in_wr_hilo;
`endif
  end

  // Ready comes only from registered occupancy, so a full FIFO never accepts
  // in the same cycle it drains.
  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign out_data  = out_valid ? w_head.res_low : '0;
  assign out_tag   = out_valid ? w_head.tag : '0;

  shift_wb_fifo u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_data  (w_in_entry),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_flags <= 3'b000;
    end else if (w_pop) begin
      r_flags <= calc_flags(w_head.res_low, w_head.amount);
    end
  end

  assign flags_q = r_flags;

`ifdef SHIFT_WB_HILO_EN
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_pop && w_head.wr_hilo) begin
      r_hi <= w_head.res_high;
      r_lo <= w_head.res_low;
    end
  end

  assign hi_q = r_hi;
  assign lo_q = r_lo;
`else
  logic w_unused_hilo;

  assign w_unused_hilo = ^{in_res_high, in_wr_hilo};
  assign hi_q          = '0;
  assign lo_q          = '0;
`endif

endmodule

// File: tb/tb_shift_writeback.sv
// Scoreboard bench for shift_writeback: driver issues directed and random results,
// a negedge monitor compares the DUT against a queue-based reference model.
module tb_shift_writeback;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_res_high;
  logic [31:0] in_res_low;
  logic [4:0]  in_amount;
  logic [4:0]  in_tag;
  logic        in_wr_hilo;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [2:0]  flags_q;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [4:0]  amt;
    logic [4:0]  tag;
    logic        wr;
  } item_t;

  item_t       modelQ [$];
  logic [2:0]  mFlags;
  logic [31:0] mHi;
  logic [31:0] mLo;
  int          vectors;
  int          miscompares;

  shift_writeback dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_res_high (in_res_high),
    .in_res_low  (in_res_low),
    .in_amount   (in_amount),
    .in_tag      (in_tag),
    .in_wr_hilo  (in_wr_hilo),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_tag     (out_tag),
    .hi_q        (hi_q),
    .lo_q        (lo_q),
    .flags_q     (flags_q)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: a plain queue plus flag/HI/LO state updated at each pop.
  always @(negedge clock) begin
    item_t it;
    logic  popNow;
    logic  pushNow;
    if (reset_n) begin
      checkOutput("out_valid", out_valid, modelQ.size() != 0);
      checkOutput("in_ready", in_ready, modelQ.size() < 2);
      if (modelQ.size() != 0) begin
        checkOutput("out_data", out_data, modelQ[0].lo);
        checkOutput("out_tag", out_tag, modelQ[0].tag);
      end
      checkOutput("flags_q", flags_q, mFlags);
      checkOutput("hi_q", hi_q, mHi);
      checkOutput("lo_q", lo_q, mLo);
      popNow  = (modelQ.size() != 0) && out_ready;
      pushNow = in_valid && (modelQ.size() < 2);
      if (popNow) begin
        it        = modelQ.pop_front();
        mFlags[0] = (it.lo == 32'd0);
        mFlags[1] = (it.lo >= 32'h8000_0000);
        mFlags[2] = (it.amt != 5'd0) && (it.lo >= 32'h8000_0000);
`ifdef SHIFT_WB_HILO_EN
        if (it.wr) begin
          mHi = it.hi;
          mLo = it.lo;
        end
`endif
      end
      if (pushNow) begin
        it.hi  = in_res_high;
        it.lo  = in_res_low;
        it.amt = in_amount;
        it.tag = in_tag;
        it.wr  = in_wr_hilo;
        modelQ.push_back(it);
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] hi, input logic [31:0] lo,
                               input logic [4:0] amt, input logic [4:0] tag, input logic wr);
    logic accepted;
    accepted    = 1'b0;
    in_valid    = 1'b1;
    in_res_high = hi;
    in_res_low  = lo;
    in_amount   = amt;
    in_tag      = tag;
    in_wr_hilo  = wr;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clock);
      if (in_ready) accepted = 1'b1;
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    checkOutput("accept_timeout", accepted, 1'b1);
  endtask

  initial begin
    logic accepted;
    vectors     = 0;
    miscompares = 0;
    mFlags      = 3'b000;
    mHi         = 32'd0;
    mLo         = 32'd0;
    reset_n     = 1'b0;
    in_valid    = 1'b0;
    in_res_high = 32'd0;
    in_res_low  = 32'd0;
    in_amount   = 5'd0;
    in_tag      = 5'd0;
    in_wr_hilo  = 1'b0;
    out_ready   = 1'b0;
    #2;
    checkOutput("reset_out_valid", out_valid, 1'b0);
    checkOutput("reset_in_ready", in_ready, 1'b1);
    checkOutput("reset_out_data", out_data, 32'd0);
    checkOutput("reset_out_tag", out_tag, 5'd0);
    checkOutput("reset_flags", flags_q, 3'b000);
    checkOutput("reset_hi", hi_q, 32'd0);
    checkOutput("reset_lo", lo_q, 32'd0);
    @(posedge clock);
    #3 reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Flag rules with immediate drain.
    out_ready = 1'b1;
    applyStimulus(32'h1234_5678, 32'h8000_0000, 5'd1, 5'd3, 1'b0);
    @(posedge clock); #1;
    checkOutput("flags_c1n1z0", flags_q, 3'b110);
    applyStimulus(32'h0, 32'h0000_0000, 5'd4, 5'd5, 1'b0);
    @(posedge clock); #1;
    checkOutput("flags_c0n0z1", flags_q, 3'b001);
    applyStimulus(32'h0, 32'h8000_0000, 5'd0, 5'd6, 1'b0);
    @(posedge clock); #1;
    checkOutput("flags_c0n1z0", flags_q, 3'b010);

    // Back-pressure: tags 1,2 fill the FIFO, tag 3 stalls.
    out_ready = 1'b0;
    applyStimulus(32'h0, 32'h0000_0011, 5'd2, 5'd1, 1'b0);
    applyStimulus(32'h0, 32'h0000_0022, 5'd2, 5'd2, 1'b0);
    in_valid   = 1'b1;
    in_res_low = 32'h0000_0033;
    in_tag     = 5'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("stall_in_ready", in_ready, 1'b0);
      checkOutput("stall_head_tag", out_tag, 5'd1);
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    accepted  = 1'b0;
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(negedge clock);
      if (in_ready) accepted = 1'b1;
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    checkOutput("stall_accept_timeout", accepted, 1'b1);
    repeat (4) @(posedge clock);
    #1;

    // HI/LO commit only at pop.
    out_ready = 1'b0;
    applyStimulus(32'hDEAD_0000, 32'h0000_BEEF, 5'd3, 5'd7, 1'b1);
    @(posedge clock); #1;
    checkOutput("hilo_hold_hi", hi_q, 32'd0);
    checkOutput("hilo_hold_lo", lo_q, 32'd0);
    out_ready = 1'b1;
    @(posedge clock); #1;
`ifdef SHIFT_WB_HILO_EN
    checkOutput("hilo_commit_hi", hi_q, 32'hDEAD_0000);
    checkOutput("hilo_commit_lo", lo_q, 32'h0000_BEEF);
`else
    checkOutput("hilo_disabled_hi", hi_q, 32'd0);
    checkOutput("hilo_disabled_lo", lo_q, 32'd0);
`endif
    checkOutput("hilo_flags", flags_q, 3'b000);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      @(posedge clock); #1;
      in_valid    = ($urandom_range(0, 2) != 0);
      in_res_high = $urandom;
      case ($urandom_range(0, 3))
        0:       in_res_low = 32'd0;
        1:       in_res_low = 32'h8000_0000 | $urandom;
        default: in_res_low = $urandom;
      endcase
      in_amount  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      in_tag     = 5'($urandom);
      in_wr_hilo = 1'($urandom);
      out_ready  = ($urandom_range(0, 3) != 0);
    end

    // Leave two entries buffered and a fresh flag value, then reset mid-cycle.
    @(posedge clock); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    out_ready = 1'b0;
    applyStimulus(32'hAAAA_5555, 32'h8000_0001, 5'd9, 5'd10, 1'b1);
    applyStimulus(32'h0, 32'h0000_0042, 5'd1, 5'd11, 1'b0);
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    checkOutput("midreset_out_valid", out_valid, 1'b0);
    checkOutput("midreset_in_ready", in_ready, 1'b1);
    checkOutput("midreset_out_data", out_data, 32'd0);
    checkOutput("midreset_flags", flags_q, 3'b000);
    checkOutput("midreset_hi", hi_q, 32'd0);
    checkOutput("midreset_lo", lo_q, 32'd0);
    modelQ.delete();
    mFlags = 3'b000;
    mHi    = 32'd0;
    mLo    = 32'd0;
    @(posedge clock);
    #3 reset_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    checkOutput("postreset_no_stale", out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
